mips_register_file: RTL
=======================

Name: mips_register_file

Overview:
32 x 32-bit MIPS general-purpose register file for the R-type single-cycle datapath.
- Sits directly upstream of the 32-bit 2:1 operand/writeback muxes.
- Supplies rs/rt operands (read_data1/read_data2) and commits the writeback value selected by the downstream mux.
- Register $0 is hardwired to zero.
- Includes a committed-write counter for bench and debug observability.

Parameters:
DATA_W, 32, register and data width in bits
ADDR_W, 5, register index width (2**ADDR_W registers)

Ports:
clk  input  1  system clock, rising-edge active
rst_n  input  1  asynchronous active-low reset
read_reg1  input  ADDR_W  rs index (instr[25:21])
read_reg2  input  ADDR_W  rt index (instr[20:16])
write_reg  input  ADDR_W  rd index for writeback
write_data  input  DATA_W  writeback value from downstream mux
reg_write  input  1  write enable from control
read_data1  output  DATA_W  contents of read_reg1
read_data2  output  DATA_W  contents of read_reg2
wr_count  output  32  number of committed writes since reset

Behaviour:
- Clocking and reset: one clock (clk). Reset rst_n is asynchronous and active-low.
- Reset state: while rst_n=0, all 32 registers clear to 0 immediately, without waiting for a clock edge, and wr_count=0. Consequently read_data1=read_data2=0 during reset.
- Reset mid-operation: a rising clk edge while rst_n=0 performs no write and no count. Normal operation resumes on the first rising edge after rst_n returns to 1.
- Write (1-cycle latency): on rising clk, if reg_write=1 and write_reg!=0, then regs[write_reg] <= write_data and wr_count <= wr_count+1.
- $0 writes: reg_write=1 with write_reg=0 is discarded, and wr_count does not increment.
- Read (0-cycle latency): read ports are combinational from the current register array. Index 0 always returns 32'h0. The two ports are fully independent; both may address the same register.
- Same-cycle read/write of the same index (base build): the read returns the old value. The new value appears after the clock edge.
- X-safety: reg_write=0 with X on write_data or write_reg must not alter any register.
- Counter: wr_count is unsigned 32-bit and wraps from 32'hFFFFFFFF to 0 with no saturation and no flag.
- Hold: with no enabled write, all registers and wr_count hold their values indefinitely.

Optional Feature:
Macro REGFILE_BYPASS_EN enables write-to-read bypass.
- Defined: if reg_write=1, write_reg!=0 and read_regN==write_reg, then read_dataN = write_data combinationally in the same cycle. This applies independently per port. $0 is never bypassed.
- Not defined: no bypass path; reads always return array contents (old value in the same cycle).
- Write timing, the $0 rule and wr_count behaviour are identical in both builds.

Test Plan:
1. Reset: drive rst_n=0 mid-cycle after loading regs -> read_data1/2 read 0 for every index 0..31 without any clk edge; wr_count=0.
2. Basic write/read: write_reg=16, write_data=32'h0211_9027, reg_write=1, one edge; then read_reg1=16 -> read_data1=32'h02119027, wr_count=1.
3. $0 write: write_reg=0, write_data=32'hFFFF_FFFF, reg_write=1, one edge -> read_data1 with read_reg1=0 returns 0; wr_count unchanged.
4. Dual-port and reg_write=0 hold:
   - Write r17=32'h0211_9020 and r18=32'h0000_0005.
   - Read read_reg1=17, read_reg2=18 -> 32'h02119020 / 32'h00000005.
   - Drive write_reg=17, write_data=0 with reg_write=0 for 3 edges -> r17 unchanged.
5. Same-cycle RAW: r8=32'h1; with read_reg1=8, present write_reg=8, write_data=32'hA5A5_A5A5, reg_write=1 before the edge.
   - Base build: read_data1=32'h1 before the edge, 32'hA5A5A5A5 after it.
   - With REGFILE_BYPASS_EN: read_data1=32'hA5A5A5A5 before the edge.
6. Counter wrap: force wr_count to 32'hFFFF_FFFF via hierarchical deposit, then one valid write to r1 -> wr_count=0; then assert rst_n=0 concurrently with a write edge -> r1=0, wr_count=0.

Source files
------------

// File: rtl/mips_register_file.sv
// mips_register_file: 32 x 32-bit MIPS general-purpose register file.
// Two combinational read ports (rs/rt) and one clocked write port (rd).
// Register $0 is hardwired to zero. wr_count tracks committed writes since reset.
// Optional build macro REGFILE_BYPASS_EN forwards a same-cycle write to a matching read port.
// When the macro is undefined, reads always return the stored array contents.

module mips_register_file #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] read_reg1,
    input  logic [ADDR_W-1:0] read_reg2,
    input  logic [ADDR_W-1:0] write_reg,
    input  logic [DATA_W-1:0] write_data,
    input  logic              reg_write,
    output logic [DATA_W-1:0] read_data1,
    output logic [DATA_W-1:0] read_data2,
    output logic [31:0]       wr_count
);

    localparam int NUM_REGS = 2 ** ADDR_W;

`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS_ON = 1'b1;
`else
    localparam bit BYPASS_ON = 1'b0;
`endif

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic [31:0]       wr_count_q;
    logic              write_en;

    // A write commits only when enabled and not aimed at $0. A low reg_write masks X on the other inputs.
    assign write_en = reg_write && (write_reg != '0);

    // Register array: cleared asynchronously on reset, otherwise updated from the write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (write_en) begin
            regs[write_reg] <= write_data;
        end
    end

    // Committed-write counter: unsigned and wraps naturally, with no saturation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_count_q <= '0;
        end else if (write_en) begin
            wr_count_q <= wr_count_q + 32'd1;
        end
    end

    assign wr_count = wr_count_q;

    // Read port 1: $0 reads as zero. A matching same-cycle write is forwarded only in the bypass build.
    always_comb begin
        read_data1 = '0;
        if (read_reg1 != '0) begin
            if (BYPASS_ON && write_en && (read_reg1 == write_reg)) begin
                read_data1 = write_data;
            end else begin
                read_data1 = regs[read_reg1];
            end
        end
    end

    // Read port 2: mirrors port 1 and is fully independent of it.
    always_comb begin
        read_data2 = '0;
        if (read_reg2 != '0) begin
            if (BYPASS_ON && write_en && (read_reg2 == write_reg)) begin
                read_data2 = write_data;
            end else begin
                read_data2 = regs[read_reg2];
            end
        end
    end

endmodule
